// File: rtl/note_voice_synth.sv
// -----------------------------------------------------------------------------
// note_voice_synth
//
// Turns a MIDI note number into an 8-bit unsigned audio sample stream.
// It has two parts:
//   - a phase-accumulator square-wave oscillator, with a note-to-increment
//     table built at elaboration;
//   - a four-state attack/sustain/release envelope.
// Both are stepped on a sample-rate strobe.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous reset, active-high
//   note_in   [7:0] MIDI note number; 60..72 sound, anything else is "no note"
//   sample_tick_in  one-cycle strobe at SAMPLE_RATE
//   sample_out[7:0] registered unsigned audio sample
//   note_out  [7:0] note currently sounding (held through release), 0 when idle
//   active_out      high whenever the voice is not idle
// -----------------------------------------------------------------------------
module note_voice_synth #(
  parameter int PHASE_W      = 24,
  parameter int SAMPLE_RATE  = 48000,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] note_in,
  input  logic       sample_tick_in,
  output logic [7:0] sample_out,
  output logic [7:0] note_out,
  output logic       active_out
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } state_e;

  localparam int NOTE_LO   = 60;
  localparam int NOTE_HI   = 72;
  localparam int NUM_NOTES = NOTE_HI - NOTE_LO + 1;

  // Equal-tempered increment for a note, rounded to nearest.
  // Evaluated only at elaboration.
  function automatic logic [PHASE_W-1:0] calc_inc(input int note);
    real freq;
    real inc_real;
    freq     = 440.0 * (2.0 ** ((note - 69) / 12.0));
    inc_real = freq * (2.0 ** PHASE_W) / SAMPLE_RATE;
    return PHASE_W'($rtoi(inc_real + 0.5));
  endfunction

  // Sixteen entries so any 4-bit index is in range.
  // Entries past the last valid note are never selected.
  logic [PHASE_W-1:0] inc_lut [16];

  for (genvar g = 0; g < 16; g++) begin : g_lut
    localparam logic [PHASE_W-1:0] INC_VAL =
      (g < NUM_NOTES) ? calc_inc(NOTE_LO + g) : '0;
    assign inc_lut[g] = INC_VAL;
  end

  state_e             state_q,    state_d;
  logic [7:0]         note_q,     note_d;
  logic [7:0]         cur_note_q, cur_note_d;
  logic [PHASE_W-1:0] inc_q,      inc_d;
  logic [PHASE_W-1:0] phase_q,    phase_d;
  logic [7:0]         level_q,    level_d;
  logic [7:0]         sample_q,   sample_d;

  logic               note_valid;
  logic               load_new;
  logic               go_silent;
  logic [3:0]         note_idx;
  logic [PHASE_W-1:0] phase_sum;
  logic [8:0]         attack_sum;

  assign note_valid = (note_q >= 8'(NOTE_LO)) && (note_q <= 8'(NOTE_HI));
  assign note_idx   = 4'(note_q - 8'(NOTE_LO));
  assign phase_sum  = phase_q + inc_q;
  assign attack_sum = {1'b0, level_q} + 9'(ATTACK_STEP);

  // A valid note that differs from the one sounding (or any valid note while
  // idle) restarts ATTACK. Going silent only matters before RELEASE.
  assign load_new  = note_valid && ((state_q == IDLE) || (note_q != cur_note_q));
  assign go_silent = !note_valid && ((state_q == ATTACK) || (state_q == SUSTAIN));

  // NOTE: every signal written here gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    note_d     = note_in;
    cur_note_d = cur_note_q;
    inc_d      = inc_q;
    phase_d    = phase_q;
    level_d    = level_q;
    sample_d   = sample_q;

    if (sample_tick_in && (state_q != IDLE)) begin
      // The phase always advances with the increment in force before this
      // edge, even when a note change lands on the same cycle.
      phase_d = phase_sum;

      // A decision on this edge takes priority over envelope stepping.
      if (!(load_new || go_silent)) begin
        unique case (state_q)
          ATTACK: begin
            if (attack_sum >= 9'd255) begin
              level_d = 8'd255;
              state_d = SUSTAIN;
            end else begin
              level_d = attack_sum[7:0];
            end
          end
          RELEASE: begin
            if (level_q <= 8'(RELEASE_STEP)) begin
              level_d = 8'd0;
              state_d = IDLE;
              phase_d = '0;
            end else begin
              level_d = level_q - 8'(RELEASE_STEP);
            end
          end
          default: ;
        endcase
      end

      sample_d = phase_sum[PHASE_W-1] ? 8'd0 : level_d;
    end

    if (load_new) begin
      // Legato: the level and the phase carry on from where they are.
      cur_note_d = note_q;
      inc_d      = inc_lut[note_idx];
      state_d    = ATTACK;
    end else if (go_silent) begin
      state_d = RELEASE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      note_q     <= '0;
      cur_note_q <= '0;
      inc_q      <= '0;
      phase_q    <= '0;
      level_q    <= '0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      cur_note_q <= cur_note_d;
      inc_q      <= inc_d;
      phase_q    <= phase_d;
      level_q    <= level_d;
      sample_q   <= sample_d;
    end
  end

  assign sample_out = sample_q;
  assign active_out = (state_q != IDLE);
  assign note_out   = (state_q != IDLE) ? cur_note_q : 8'd0;

endmodule
